// File: rtl/wire_sequence.sv
// Wire-cutting puzzle: synchronised and debounced wire sense, a snapshot of the connected set at arm time, and an ordered cut sequence.
// A stable wire change is judged DEBOUNCE_CYCLES+3 cycles after it appears on wire_in; there is no backpressure.
module wire_sequence #(
   parameter int N_WIRES         = 6,
   parameter int MAX_CUTS        = 3,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2:0]         current_state,
   input  logic               sn_last_pos_odd,
   input  logic [N_WIRES-1:0] wire_in,
   output logic               activated,
   output logic               module_failed,
   output logic               module_solved,
   output logic               config_error,
   output logic [3:0]         strike_count
);

   localparam logic [2:0] GS_ACTIVATING = 3'b001;
   localparam logic [2:0] GS_ACTIVATED  = 3'b010;
   localparam logic [7:0] DB_LEN        = 8'(DEBOUNCE_CYCLES);
   localparam logic [3:0] MAX_K         = 4'(MAX_CUTS);

   typedef enum logic [2:0] {S_IDLE, S_ARM, S_ACTIVE, S_SOLVED, S_FAULT} state_t;

   function automatic logic [3:0] popcnt(input logic [N_WIRES-1:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < N_WIRES; i++) n = n + {3'b000, v[i]};
      return n;
   endfunction

   logic [N_WIRES-1:0] sync1_q, sync2_q, cand_q, db_q, db_d, db_prev_q;
   logic [7:0]         db_cnt_q, db_cnt_d;

   // cand_q is last cycle's synchronised value; a change of value restarts the count
   always_comb begin
      db_d = db_q;
      if (sync2_q == db_q) begin
         db_cnt_d = '0;
      end else if (sync2_q != cand_q) begin
         db_cnt_d = 8'd1;
      end else begin
         db_cnt_d = db_cnt_q + 8'd1;
      end
      if (db_cnt_d >= DB_LEN) begin
         db_d     = sync2_q;
         db_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         cand_q    <= '0;
         db_cnt_q  <= '0;
         db_q      <= '0;
         db_prev_q <= '0;
      end else begin
         sync1_q   <= wire_in;
         sync2_q   <= sync1_q;
         cand_q    <= sync2_q;
         db_cnt_q  <= db_cnt_d;
         db_q      <= db_d;
         db_prev_q <= db_q;
      end
   end

   state_t             state_q, state_d;
   logic [3:0]         step_q, step_d;
   logic [3:0]         strikes_q, strikes_d;
   logic [N_WIRES-1:0] conn_q, conn_d;
   logic               odd_q, odd_d;
   logic               act_q, act_d;
   logic               fail_q, fail_d;

   logic [3:0]         conn_cnt, k_half, seq_len;
   logic [N_WIRES-1:0] tgt_mask, fut_mask, falls;
   logic [3:0]         fall_cnt, rank_v, pos_v;

   assign conn_cnt = popcnt(conn_q);
   assign k_half   = conn_cnt >> 1;
   assign seq_len  = (k_half > MAX_K) ? MAX_K : k_half;
   assign falls    = db_prev_q & ~db_q;
   assign fall_cnt = popcnt(falls);

   // Step position of each connected wire; consumed steps fall in neither mask
   always_comb begin
      tgt_mask = '0;
      fut_mask = '0;
      rank_v   = '0;
      pos_v    = '0;
      for (int i = 0; i < N_WIRES; i++) begin
         pos_v = odd_q ? (conn_cnt - 4'd1 - rank_v) : rank_v;
         if (conn_q[i]) begin
            if (pos_v == step_q && pos_v < seq_len) tgt_mask[i] = 1'b1;
            if (pos_v > step_q && pos_v < seq_len)  fut_mask[i] = 1'b1;
            rank_v = rank_v + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         step_q    <= '0;
         strikes_q <= '0;
         conn_q    <= '0;
         odd_q     <= 1'b0;
         act_q     <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         strikes_q <= strikes_d;
         conn_q    <= conn_d;
         odd_q     <= odd_d;
         act_q     <= act_d;
         fail_q    <= fail_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      strikes_d = strikes_q;
      conn_d    = conn_q;
      odd_d     = odd_q;
      act_d     = 1'b0;
      fail_d    = 1'b0;
      if (state_q == S_ARM) begin
         conn_d = db_q;
         odd_d  = sn_last_pos_odd;
      end
      if (current_state == GS_ACTIVATING) begin
         state_d   = S_ARM;
         step_d    = '0;
         strikes_d = '0;
      end else if (current_state == GS_ACTIVATED) begin
         case (state_q)
            S_ARM: begin
               if (popcnt(db_q) < 4'd2) begin
                  state_d = S_FAULT;
               end else begin
                  state_d = S_ACTIVE;
                  act_d   = 1'b1;
               end
            end
            S_ACTIVE: begin
               if (falls != '0) begin
                  if (fall_cnt == 4'd1 && (falls & tgt_mask) != '0) begin
                     step_d = step_q + 4'd1;
                     if (step_q + 4'd1 == seq_len) state_d = S_SOLVED;
                  end else begin
                     fail_d = 1'b1;
                     if (strikes_q != 4'hF) strikes_d = strikes_q + 4'd1;
                     if ((falls & fut_mask) != '0) state_d = S_FAULT;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      activated     = act_q;
      module_failed = fail_q;
      module_solved = (state_q == S_SOLVED);
      config_error  = (state_q == S_FAULT);
      strike_count  = strikes_q;
   end

endmodule
